// File: rtl/threshold_setter_writer.sv
// Writer side of the threshold-setter link: sequences glitch-free write/clear strobes with
// setup and hold margins. Define THRESHOLD_RANGE_CHECK_EN to reject out-of-range write values.
module threshold_setter_writer #(
  parameter int unsigned SETUP_CYCLES      = 1,
  parameter int unsigned STROBE_CYCLES     = 2,
  parameter int unsigned HOLD_CYCLES       = 1,
  parameter logic [31:0] DEFAULT_THRESHOLD = 32'd1,
  parameter logic [31:0] THRESH_MIN        = 32'h0000_0000,
  parameter logic [31:0] THRESH_MAX        = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_clear,
  input  logic [31:0] req_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] shadow,
  output logic [31:0] setter_threshold,
  output logic        setter_write,
  output logic        setter_reset
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255 || STROBE_CYCLES < 1 || STROBE_CYCLES > 255 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || THRESH_MIN > THRESH_MAX) begin : g_bad_params
    $error("threshold_setter_writer: illegal parameter set");
  end

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        clr, clr_nxt;
  logic [31:0] thr_nxt, shadow_nxt;
  logic        write_nxt, sreset_nxt, ready_nxt, busy_nxt, done_nxt, err_nxt;
  logic        in_range;

`ifdef THRESHOLD_RANGE_CHECK_EN
  // 33-bit differences: the borrow bit flags a value below MIN or above MAX.
  logic [32:0] lo_diff, hi_diff;
  assign lo_diff  = {1'b0, req_data} - {1'b0, THRESH_MIN};
  assign hi_diff  = {1'b0, THRESH_MAX} - {1'b0, req_data};
  assign in_range = !lo_diff[32] && !hi_diff[32];
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    clr_nxt    = clr;
    thr_nxt    = setter_threshold;
    shadow_nxt = shadow;
    ready_nxt  = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (req_valid && req_ready) begin
          if (req_clear || in_range) begin
            state_nxt = SETUP;
            cnt_nxt   = SETUP_LD;
            clr_nxt   = req_clear;
            thr_nxt   = req_clear ? DEFAULT_THRESHOLD : req_data;
            ready_nxt = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      STROBE: begin
        if (cnt == 8'd0) begin
          state_nxt  = HOLD;
          cnt_nxt    = HOLD_LD;
          shadow_nxt = setter_threshold;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Strobes are decoded from the next state so the outputs themselves come straight from flops.
    write_nxt  = (state_nxt == STROBE) && !clr_nxt;
    sreset_nxt = (state_nxt == STROBE) && clr_nxt;
    busy_nxt   = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= 8'd0;
      clr              <= 1'b0;
      setter_threshold <= DEFAULT_THRESHOLD;
      shadow           <= DEFAULT_THRESHOLD;
      setter_write     <= 1'b0;
      setter_reset     <= 1'b1;
      req_ready        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      clr              <= clr_nxt;
      setter_threshold <= thr_nxt;
      shadow           <= shadow_nxt;
      setter_write     <= write_nxt;
      setter_reset     <= sreset_nxt;
      req_ready        <= ready_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
      err              <= err_nxt;
    end
  end

endmodule

// File: tb/tb_threshold_setter_writer.sv
// Self-checking bench for threshold_setter_writer: directed and random requests against a
// timeline model of the strobe sequence plus a reader model that latches on strobe edges.
module tb_threshold_setter_writer;

  localparam int          S    = 1;
  localparam int          T    = 2;
  localparam int          H    = 1;
  localparam int          LAT  = S + T + H;
  localparam logic [31:0] DEF  = 32'd1;
  localparam logic [31:0] TMIN = 32'd0;
  localparam logic [31:0] TMAX = 32'd1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_clear = 1'b0;
  logic [31:0] req_data = 32'd0;
  logic        req_ready, busy, done, err, setter_write, setter_reset;
  logic [31:0] shadow, setter_threshold;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] model_shadow = DEF;
  logic [31:0] model_thr = DEF;
  logic [31:0] reader_val = DEF;
  logic [31:0] latched[$];
  time         rise_t[$];
  int          write_rises = 0;
  int          reset_rises = 0;

  threshold_setter_writer #(
    .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H),
    .DEFAULT_THRESHOLD(DEF), .THRESH_MIN(TMIN), .THRESH_MAX(TMAX)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_clear(req_clear), .req_data(req_data), .busy(busy), .done(done), .err(err),
    .shadow(shadow), .setter_threshold(setter_threshold), .setter_write(setter_write),
    .setter_reset(setter_reset)
  );

  always #5 clk = ~clk;

  // Reader model: latches on the rising edge of write, clears on the rising edge of reset.
  always @(posedge setter_write) begin
    write_rises <= write_rises + 1;
    reader_val  <= setter_threshold;
    latched.push_back(setter_threshold);
    rise_t.push_back($time);
  end
  always @(posedge setter_reset) begin
    reset_rises <= reset_rises + 1;
    reader_val  <= DEF;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit rejected(input bit c, input logic [31:0] d);
`ifdef THRESHOLD_RANGE_CHECK_EN
    return !c && (d < TMIN || d > TMAX);
`else
    return 1'b0;
`endif
  endfunction

  // One request from handshake through completion, checked cycle by cycle against the timeline.
  task automatic run_req(input bit c, input logic [31:0] d);
    bit          rej;
    logic [31:0] newv, oldv;
    int          w0, r0, tmo;
    bit          strobe;
    rej  = rejected(c, d);
    newv = c ? DEF : d;
    oldv = model_shadow;
    tmo  = 0;
    while (req_ready !== 1'b1 && tmo < 20) begin
      tick();
      tmo++;
    end
    chk("ready_before_req", req_ready, 1);
    w0 = write_rises;
    r0 = reset_rises;
    req_valid = 1'b1;
    req_clear = c;
    req_data  = d;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      if (rej) begin
        chk("rej_err", err, (k == 0) ? 1 : 0);
        chk("rej_ready", req_ready, 1);
        chk("rej_busy", busy, 0);
        chk("rej_write", setter_write, 0);
        chk("rej_sreset", setter_reset, 0);
        chk("rej_thr", setter_threshold, model_thr);
        chk("rej_shadow", shadow, oldv);
        chk("rej_done", done, 0);
      end else begin
        strobe = (k >= S) && (k < S + T);
        chk("seq_write", setter_write, (strobe && !c) ? 1 : 0);
        chk("seq_sreset", setter_reset, (strobe && c) ? 1 : 0);
        chk("seq_thr", setter_threshold, newv);
        chk("seq_shadow", shadow, (k >= S + T) ? newv : oldv);
        chk("seq_done", done, (k == LAT) ? 1 : 0);
        chk("seq_busy", busy, (k < LAT) ? 1 : 0);
        chk("seq_ready", req_ready, (k == LAT) ? 1 : 0);
        chk("seq_err", err, 0);
      end
      if (k < LAT) tick();
    end
    chk("write_pulses", write_rises - w0, (!rej && !c) ? 1 : 0);
    chk("clear_pulses", reset_rises - r0, (!rej && c) ? 1 : 0);
    if (!rej) begin
      model_shadow = newv;
      model_thr    = newv;
    end
    chk("reader_value", reader_val, model_shadow);
  endtask

  initial begin
    int          n0, hs_idx, dn;
    int          hs_cyc[3];
    logic [31:0] vals[3];
    bit          hs;
    vals[0] = 32'd10;
    vals[1] = 32'd20;
    vals[2] = 32'd30;

    // Reset release
    #1 reset = 1'b1;
    repeat (3) tick();
    chk("rst_sreset", setter_reset, 1);
    chk("rst_shadow", shadow, DEF);
    chk("rst_ready", req_ready, 0);
    chk("rst_write", setter_write, 0);
    chk("rst_thr", setter_threshold, DEF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    tick();
    chk("rel_sreset", setter_reset, 0);
    chk("rel_ready", req_ready, 1);

    // Default write, then a clear with all-ones data
    run_req(1'b0, 32'h0000_1234);
    run_req(1'b0, 32'd500);
    run_req(1'b1, 32'hFFFF_FFFF);
    chk("clear_reader_default", reader_val, DEF);

    // Back-to-back with req_valid held high
    n0 = latched.size();
    hs_idx = 0;
    req_valid = 1'b1;
    req_clear = 1'b0;
    req_data  = vals[0];
    for (int c = 0; c < 40 && hs_idx < 3; c++) begin
      hs = req_ready;
      chk("b2b_ready_vs_busy", req_ready && busy, 0);
      tick();
      if (hs) begin
        hs_cyc[hs_idx] = c;
        hs_idx++;
        if (hs_idx < 3) req_data = vals[hs_idx];
      end
    end
    req_valid = 1'b0;
    chk("b2b_handshakes", hs_idx, 3);
    if (hs_idx == 3) begin
      chk("b2b_spacing01", hs_cyc[1] - hs_cyc[0], LAT + 1);
      chk("b2b_spacing12", hs_cyc[2] - hs_cyc[1], LAT + 1);
    end
    repeat (LAT + 2) tick();
    chk("b2b_write_count", latched.size() - n0, 3);
    if (latched.size() == n0 + 3) begin
      for (int i = 0; i < 3; i++) chk("b2b_latched", latched[n0 + i], vals[i]);
      chk("b2b_rise_gap1", 32'(rise_t[n0 + 1] - rise_t[n0]), 10 * (LAT + 1));
      chk("b2b_rise_gap2", 32'(rise_t[n0 + 2] - rise_t[n0 + 1]), 10 * (LAT + 1));
    end
    chk("b2b_shadow", shadow, 32'd30);
    model_shadow = 32'd30;
    model_thr    = 32'd30;

    // Range boundary: 1000 accepted, 1001 written or rejected depending on the build
    run_req(1'b0, TMAX);
    run_req(1'b0, TMAX + 32'd1);

    // Random mix of writes and clears
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_req($urandom_range(0, 3) == 0, (r % 4 == 0) ? $urandom() : $urandom_range(0, 2000));
    end

    // Reset while write is high
    tick();
    req_valid = 1'b1;
    req_clear = 1'b0;
    req_data  = 32'd777;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10 && setter_write !== 1'b1; i++) tick();
    chk("mid_write_high", setter_write, 1);
    reset = 1'b1;
    #1;
    chk("mid_write_drop", setter_write, 0);
    chk("mid_sreset", setter_reset, 1);
    chk("mid_ready", req_ready, 0);
    chk("mid_busy", busy, 0);
    chk("mid_shadow", shadow, DEF);
    chk("mid_thr", setter_threshold, DEF);
    tick();
    tick();
    reset = 1'b0;
    model_shadow = DEF;
    model_thr    = DEF;
    dn = 0;
    tick();
    chk("mid_rel_sreset", setter_reset, 0);
    chk("mid_rel_ready", req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) dn++;
      tick();
    end
    chk("mid_no_done", dn, 0);
    chk("mid_idle_busy", busy, 0);
    chk("mid_reader_cleared", reader_val, DEF);

    run_req(1'b0, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/threshold_setter_writer.md
# threshold_setter_writer

Writer side of the threshold-setter interface: accepts threshold update and clear requests from the configuration path through a valid/ready handshake and drives `threshold`, `write` and `reset` of a `ThresholdSetterInterface` port. Detectors on the reader side latch on the rising edge of `write` and clear on the rising edge of `reset`. This block therefore sequences those strobes glitch-free, with data setup and hold margins, and keeps a shadow copy of the last committed value for status readback.

## Interface
- `SETUP_CYCLES`, 1: cycles `threshold` is stable before the strobe rises; legal 1..255.
- `STROBE_CYCLES`, 2: strobe high time in cycles; legal 1..255.
- `HOLD_CYCLES`, 1: cycles `threshold` is held after the strobe falls; legal 1..255.
- `DEFAULT_THRESHOLD`, 1: shadow value after reset or clear; must equal the reader's `resetValue`.
- `THRESH_MIN`, 32'h0000_0000: lowest accepted value (range check only).
- `THRESH_MAX`, 32'hFFFF_FFFF: highest accepted value (range check only).

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request.
- `req_clear`  in  1: 1 = clear command; `req_data` is ignored.
- `req_data`  in  32: new threshold, unsigned.
- `busy`  out  1: sequence in progress (state ≠ IDLE).
- `done`  out  1: one-cycle pulse when a sequence completes.
- `err`  out  1: one-cycle pulse on a rejected value.
- `shadow`  out  32: last committed threshold.
- `setter`  interface  `ThresholdSetterInterface.writer`: drives `threshold[31:0]`, `write` and `reset`.

## Operation
- All interface outputs are driven straight from flops. No combinational logic follows them, because the reader uses `write` and `reset` as clocks.
- Reset values:
  - FSM = IDLE.
  - `setter.reset` = 1, `setter.write` = 0, `setter.threshold` = `DEFAULT_THRESHOLD`.
  - `shadow` = `DEFAULT_THRESHOLD`.
  - `req_ready` = 0, `busy` = 0, `done` = 0, `err` = 0.
- First clock edge after `reset` deasserts: `setter.reset` goes to 0 and `req_ready` goes to 1.
- FSM states:
  - **IDLE**: `req_ready` = 1. A handshake (`req_valid` && `req_ready`) captures `req_clear` and `req_data` and moves to SETUP. Exception: a value rejected by the range check does not leave IDLE.
  - **SETUP**: `setter.threshold` = captured data (clear: `DEFAULT_THRESHOLD`); both strobes low. Lasts `SETUP_CYCLES`, then STROBE.
  - **STROBE**: write command drives `setter.write` = 1; clear command drives `setter.reset` = 1. The other strobe stays 0. Lasts `STROBE_CYCLES`, then HOLD.
  - **HOLD**: strobes low, `threshold` held. `shadow` updates on the edge entering HOLD. Lasts `HOLD_CYCLES`, then IDLE with `done` = 1 for that one cycle.
- `req_ready` = 0 in every state except IDLE, so no request is accepted mid-sequence.
- A single 8-bit down-counter times every state. It is loaded with the state's parameter minus 1 on entry.
- `setter.threshold` is only changed on the edge entering SETUP.
- Asserting `reset` mid-sequence forces all reset values immediately. An in-progress `write` is cut short and the reader is cleared by `setter.reset`.

## Timing
- Handshake sampled at edge E0:
  - SETUP from E0.
  - `write`/`reset` rises at E0+S and falls at E0+S+T.
  - `done` is high and `req_ready` = 1 in the cycle after E0+S+T+H.
- Minimum request spacing is S+T+H+1 cycles. Defaults: 5.
- `done` and `err` are never both high in the same cycle.

## Configuration
- `THRESHOLD_RANGE_CHECK_EN` defined:
  - A write request with `req_data` < `THRESH_MIN` or > `THRESH_MAX` is still consumed by the handshake.
  - No setter activity occurs and `shadow` is unchanged.
  - `err` = 1 in the cycle after the handshake; the FSM stays in IDLE and `req_ready` stays 1.
  - Clear requests are never rejected.
- Macro undefined: `err` is tied to 0, every value is written, and `THRESH_MIN`/`THRESH_MAX` are unused.

## Test plan
- **Reset release:** hold `reset` for 3 cycles, then release.
  - During reset: `setter.reset` = 1, `shadow` = 1, `req_ready` = 0.
  - After the first edge: `setter.reset` = 0, `req_ready` = 1.
- **Default write:** write 32'h0000_1234.
  - `threshold` = 32'h1234 one cycle before `write` rises.
  - `write` high exactly 2 cycles; `threshold` stable through 1 cycle after `write` falls.
  - `shadow` = 32'h1234; `done` pulses at the 5th cycle after E0.
- **Back-to-back:** keep `req_valid` high with 10, 20, 30.
  - Exactly three `write` pulses, 5 cycles apart.
  - Reader latches 10, 20, 30 in order; `req_ready` low while `busy`.
- **Clear:** issue a clear with `req_data` = 32'hFFFF_FFFF.
  - `setter.reset` pulses for 2 cycles and `write` stays 0.
  - `shadow` = `DEFAULT_THRESHOLD`; reader compares against 1.
- **Reset mid-strobe:** assert `reset` while `write` = 1.
  - `write` drops immediately and `setter.reset` = 1.
  - FSM returns to IDLE; no `done` pulse.
- **Range check:** with the macro and `THRESH_MAX` = 1000, write 1001.
  - `err` pulses once, no strobe, `shadow` unchanged.
  - Without the macro the same stimulus writes 1001.
